tick_sequencer: RTL and testbench

TICK_SEQUENCER -- requirements
Module: tick_sequencer

---
 rtl/snn_ctrl_pkg.sv | 12 +
 rtl/tick_watchdog.sv | 25 ++
 rtl/tick_sequencer.sv | 124 ++++++++++++
 tb/tb_tick_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg: state encoding and default widths shared by the tick sequencer and grid controller
package snn_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

endpackage

// File: rtl/tick_watchdog.sv
// tick_watchdog: counts enabled cycles and flags expiry on the LIMIT-th consecutive one
module tick_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_q;

    assign expired = enable && cnt_q == W'(LIMIT - 1);

    // dwell counter, restarted whenever the watched condition drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/tick_sequencer.sv
// tick_sequencer: issues paced timestep ticks to the neuron grid controller; TICK_WATCHDOG_EN adds a WAIT_DONE watchdog
module tick_sequencer
    import snn_ctrl_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_ticks,
    input  logic [CNT_W-1:0] period,
    input  logic             done,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] tick_count,
    output logic             seq_done,
    output logic             proto_err,
    output logic             timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, period_q, period_d, gap_q, gap_d, count_q, count_d;
    logic             tick_q, tick_d, busy_q, busy_d, seq_done_q, seq_done_d, proto_q, proto_d;
    logic             accept, done_ok, gap_over, wd_expired;

    assign accept  = state_q == S_IDLE && start && !abort;
    assign done_ok = state_q == S_WAIT_DONE && done && !abort;
    // ISSUE plus the registered tick cost two cycles, so leaving GAP two counts early makes tick-to-tick spacing equal period
    assign gap_over = ({1'b0, gap_q} + (CNT_W+1)'(2)) >= {1'b0, period_q};

`ifdef TICK_WATCHDOG_EN
    logic tmo_q;

    tick_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != S_WAIT_DONE),
        .enable  (state_q == S_WAIT_DONE),
        .expired (wd_expired)
    );

    // sticky timeout flag; a done arriving on the expiry cycle still wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= 1'b0;
        else tmo_q <= (tmo_q && !accept) || (wd_expired && !done && !abort);
    end

    assign timeout_err = tmo_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // next-state logic; abort overrides everything else
    always_comb begin
        state_d = state_q;
        if (abort) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE:      if (start) state_d = num_ticks == '0 ? S_FINISH : S_ISSUE;
                S_ISSUE:     state_d = S_WAIT_DONE;
                S_WAIT_DONE: if (done) state_d = count_q + 1'b1 == num_q ? S_FINISH : S_GAP;
                             else if (wd_expired) state_d = S_IDLE;
                S_GAP:       if (gap_over) state_d = S_ISSUE;
                S_FINISH:    state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // registered outputs and datapath next values
    always_comb begin
        tick_d     = state_q == S_ISSUE && !abort;
        busy_d     = state_d != S_IDLE;
        seq_done_d = state_q == S_FINISH && !abort;
        num_d      = accept ? num_ticks : num_q;
        period_d   = accept ? period : period_q;
        count_d    = accept ? '0 : done_ok ? count_q + 1'b1 : count_q;
        gap_d      = state_q == S_ISSUE ? '0 : &gap_q ? gap_q : gap_q + 1'b1;
        proto_d    = (proto_q && !accept) || (done && !abort && state_q != S_WAIT_DONE);
    end

    // output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            proto_q    <= 1'b0;
            num_q      <= '0;
            period_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
        end else begin
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            proto_q    <= proto_d;
            num_q      <= num_d;
            period_q   <= period_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
        end
    end

    assign tick       = tick_q;
    assign busy       = busy_q;
    assign seq_done   = seq_done_q;
    assign proto_err  = proto_q;
    assign tick_count = count_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: directed self-checking bench for tick_sequencer (TIMEOUT_CYCLES=16)
module tb_tick_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, done = 1'b0;
    logic [W-1:0] num_ticks = '0, period = '0;
    logic         tick, busy, seq_done, proto_err, timeout_err;
    logic [W-1:0] tick_count;
    int           n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    tick_sequencer #(.CNT_W(W), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_ticks   (num_ticks),
        .period      (period),
        .done        (done),
        .tick        (tick),
        .busy        (busy),
        .tick_count  (tick_count),
        .seq_done    (seq_done),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start is presented for one edge; on return the bench sits in cycle 0 after the start edge
    task automatic launch(input int n, input int p);
        num_ticks = W'(n);
        period    = W'(p);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        int ticks[$];
        int last, sd, sd_at, ab, tk, t16, t17, b17, b_after, cnt_after;

        #12;
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("idle_busy", busy, 0);

        // three ticks, period 10, done 4 cycles after each tick
        launch(3, 10);
        chk("p10_busy_c0", busy, 1);
        chk("p10_tick_c0", tick, 0);
        last = -100; sd = 0; sd_at = -1;
        for (int c = 1; c <= 35; c++) begin
            step();
            if (tick) begin ticks.push_back(c); last = c; end
            if (seq_done) begin sd++; sd_at = c; end
            done = c == last + 4;
        end
        done = 1'b0;
        chk("p10_num_ticks", ticks.size(), 3);
        while (ticks.size() < 3) ticks.push_back(-1);
        chk("p10_tick1_at", ticks[0], 1);
        chk("p10_tick2_at", ticks[1], 11);
        chk("p10_tick3_at", ticks[2], 21);
        chk("p10_seq_done_cnt", sd, 1);
        chk("p10_seq_done_at", sd_at, 27);
        chk("p10_tick_count", tick_count, 3);
        chk("p10_busy_end", busy, 0);
        chk("p10_proto_err", proto_err, 0);

        // zero-tick sequence goes straight to FINISH
        launch(0, 5);
        chk("zero_busy_c0", busy, 1);
        chk("zero_tick_count_c0", tick_count, 0);
        step();
        chk("zero_seq_done_c1", seq_done, 1);
        chk("zero_busy_c1", busy, 0);
        chk("zero_tick_c1", tick, 0);
        step();
        chk("zero_seq_done_c2", seq_done, 0);

        // five ticks, period 0, abort while waiting on the third done
        ticks.delete();
        launch(5, 0);
        last = -100; sd = 0; ab = -1; b_after = -1; cnt_after = -1;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (tick) begin ticks.push_back(c); last = c; end
            if (seq_done) sd++;
            if (c == ab + 1) begin b_after = busy; cnt_after = tick_count; end
            abort = ticks.size() == 3 && ab < 0;
            if (abort) ab = c;
            done = ab < 0 && c == last + 2;
        end
        abort = 1'b0;
        done  = 1'b0;
        chk("abort_num_ticks", ticks.size(), 3);
        chk("abort_at_tick3", ab, 11);
        chk("abort_busy_next", b_after, 0);
        chk("abort_count_next", cnt_after, 2);
        chk("abort_seq_done_cnt", sd, 0);
        chk("abort_tick_count_end", tick_count, 2);

        // done in IDLE sets a sticky protocol error, cleared by the next start
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("proto_set", proto_err, 1);
        chk("proto_idle_busy", busy, 0);
        step();
        chk("proto_sticky", proto_err, 1);
        launch(1, 0);
        chk("proto_cleared", proto_err, 0);
        chk("proto_run_busy", busy, 1);
        step();
        chk("proto_run_tick", tick, 1);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("proto_run_seq_done", seq_done, 1);
        chk("proto_run_tick_count", tick_count, 1);
        chk("proto_run_proto_err", proto_err, 0);

        // done never returned
        launch(1, 0);
        tk = 0; sd = 0; t16 = -1; t17 = -1; b17 = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            tk += int'(tick);
            sd += int'(seq_done);
            if (c == 16) t16 = timeout_err;
            if (c == 17) begin t17 = timeout_err; b17 = busy; end
        end
        chk("wd_ticks", tk, 1);
        chk("wd_seq_done_cnt", sd, 0);
`ifdef TICK_WATCHDOG_EN
        chk("wd_tmo_c16", t16, 0);
        chk("wd_tmo_c17", t17, 1);
        chk("wd_busy_c17", b17, 0);
`else
        chk("nowd_tmo_c16", t16, 0);
        chk("nowd_tmo_c17", t17, 0);
        chk("nowd_busy_c17", b17, 1);
        chk("nowd_busy_end", busy, 1);
        num_ticks = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("busy_start_ignored", busy, 1);
        chk("busy_start_no_seq_done", seq_done, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("nowd_abort_busy", busy, 0);
`endif

        // async reset while in GAP with one tick counted
        launch(3, 20);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("gap_pre_count", tick_count, 1);
        chk("gap_pre_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("gap_rst_tick", tick, 0);
        chk("gap_rst_busy", busy, 0);
        chk("gap_rst_count", tick_count, 0);
        chk("gap_rst_seq_done", seq_done, 0);
        chk("gap_rst_proto", proto_err, 0);
        chk("gap_rst_tmo", timeout_err, 0);
        step();
        step();
        reset = 1'b0;
        tk = 0; sd = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            tk += int'(tick);
            sd += int'(busy);
        end
        chk("post_rst_ticks", tk, 0);
        chk("post_rst_busy_cycles", sd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
